// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register offsets, STATUS/CTRL bit layouts and FSM encodings for uart_ctrl
package uart_ctrl_pkg;
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLR    = 2'd3;
  typedef struct packed {
    logic [3:0] rsvd;
    logic       tx_drop;
    logic       rx_ovf;
    logic       tx_pend;
    logic       rx_avail;
  } status_t;
  typedef struct packed {
    logic [5:0] rsvd;
    logic       tx_ie;
    logic       rx_ie;
  } ctrl_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_GAP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PUSH, R_CLR} rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two byte queue with occupancy count; caller never pushes when full unless also popping
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_i);
      rp_q  <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped uart0 controller with TX holding register and RX queue; UART_CTRL_IRQ_EN enables CTRL and irq
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int RXQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic [7:0] u_din,
  output logic       u_txd_ld,
  input  logic       u_txd_busy,
  input  logic       u_rxd_rdy,
  input  logic [7:0] u_dout,
  output logic       u_rxd_ft
);
  localparam int CW = $clog2(RXQ_DEPTH) + 1;
  tx_state_e     tx_q, tx_d;
  rx_state_e     rx_q, rx_d;
  logic [7:0]    hold_q, hold_d, rdata_q, rdata_d, f_dout, ctrl_rd;
  logic          tx_pend_q, tx_pend_d, tx_drop_q, tx_drop_d, rx_ovf_q, rx_ovf_d;
  logic          f_push, f_pop, f_full, f_empty, wr_data, wr_clr;
  logic [CW-1:0] f_cnt;
  status_t       status;
  uart_rx_fifo #(.DEPTH(RXQ_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (f_push),
    .pop_i  (f_pop),
    .din_i  (u_dout),
    .dout_o (f_dout),
    .count_o(f_cnt),
    .full_o (f_full),
    .empty_o(f_empty)
  );
  always_comb begin
    wr_data   = wr_en && addr == A_DATA;
    wr_clr    = wr_en && addr == A_CLR;
    f_pop     = rd_en && addr == A_DATA && !f_empty;
    f_push    = rx_q == R_PUSH && (!f_full || f_pop);
    status    = '{rsvd: 4'h0, tx_drop: tx_drop_q, rx_ovf: rx_ovf_q, tx_pend: tx_pend_q, rx_avail: f_cnt != '0};
    tx_d      = tx_q == T_IDLE ? (tx_pend_q && !u_txd_busy ? T_LOAD : T_IDLE) : tx_q == T_LOAD ? T_GAP : T_IDLE;
    rx_d      = rx_q == R_IDLE ? (u_rxd_rdy ? R_PUSH : R_IDLE) : rx_q == R_PUSH ? R_CLR : R_IDLE;
    hold_d    = wr_data && !tx_pend_q ? wdata : hold_q;
    tx_pend_d = tx_q == T_LOAD ? 1'b0 : tx_pend_q || wr_data;
    tx_drop_d = (tx_drop_q && !(wr_clr && wdata[1])) || (wr_data && tx_pend_q);
    rx_ovf_d  = (rx_ovf_q && !(wr_clr && wdata[0])) || (rx_q == R_PUSH && f_full && !f_pop);
    rdata_d   = !rd_en ? rdata_q :
                addr == A_DATA ? (f_empty ? 8'h00 : f_dout) :
                addr == A_STATUS ? status :
                addr == A_CTRL ? ctrl_rd : 8'h00;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q      <= T_IDLE;
      rx_q      <= R_IDLE;
      hold_q    <= '0;
      rdata_q   <= '0;
      tx_pend_q <= 1'b0;
      tx_drop_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      hold_q    <= hold_d;
      rdata_q   <= rdata_d;
      tx_pend_q <= tx_pend_d;
      tx_drop_q <= tx_drop_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end
`ifdef UART_CTRL_IRQ_EN
  ctrl_t ctrl_q, ctrl_d;
  logic  irq_q, irq_d;
  always_comb begin
    ctrl_d = wr_en && addr == A_CTRL ? ctrl_t'({6'h0, wdata[1:0]}) : ctrl_q;
    irq_d  = (ctrl_q.rx_ie && f_cnt != '0) || (ctrl_q.tx_ie && !tx_pend_q) || (ctrl_q.rx_ie && rx_ovf_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end
  assign ctrl_rd = ctrl_q;
  assign irq     = irq_q;
`else
  assign ctrl_rd = 8'h00;
  assign irq     = 1'b0;
`endif
  assign rdata    = rdata_q;
  assign u_din    = hold_q;
  assign u_txd_ld = tx_q == T_LOAD;
  assign u_rxd_ft = rx_q == R_CLR;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: table-driven register checks plus scoreboarded TX/RX corner sequences for uart_ctrl
module tb_uart_ctrl;
  localparam logic [1:0] AD = 2'd0, AS = 2'd1, AC = 2'd2, AK = 2'd3;
`ifdef UART_CTRL_IRQ_EN
  localparam logic [7:0] CTRL_RB = 8'h03;
`else
  localparam logic [7:0] CTRL_RB = 8'h00;
`endif
  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
    string      n;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wdata = 8'h00, rdata, u_din, u_dout = 8'h00;
  logic       irq, u_txd_ld, u_txd_busy = 1'b0, u_rxd_rdy = 1'b0, u_rxd_ft;
  int         checks = 0, errors = 0, cyc = 0, ld_cnt = 0, ld_cyc = 0;
  logic [7:0] rd_sb[$], tx_sb[$];
  string      nm_sb[$];
  vec_t       vt[10];
  uart_ctrl #(.RXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .irq(irq), .u_din(u_din), .u_txd_ld(u_txd_ld),
    .u_txd_busy(u_txd_busy), .u_rxd_rdy(u_rxd_rdy), .u_dout(u_dout), .u_rxd_ft(u_rxd_ft)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", n, act, exp);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    if (rd_en && rst) begin
      #1;
      if (rd_sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got %02h expected none", rdata);
      end else chk(nm_sb.pop_front(), rdata, rd_sb.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (u_txd_ld) begin
      ld_cnt++;
      ld_cyc = cyc;
      if (tx_sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected got %02h expected none", u_din);
      end else chk("tx_din", u_din, tx_sb.pop_front());
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic bus_rd(input logic [1:0] a, input logic [7:0] e, input string n);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    rd_sb.push_back(e);
    nm_sb.push_back(n);
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    u_dout = b; u_rxd_rdy = 1'b1;
    for (int i = 0; i < 10 && !u_rxd_ft; i++) @(negedge clk);
    chk("rx_ft_seen", 8'(u_rxd_ft), 8'd1);
    u_rxd_rdy = 1'b0;
  endtask
  initial begin
    int base, wcyc;
    vt[0] = '{1'b0, AS, 8'h00, 8'h00, "rst_status"};
    vt[1] = '{1'b0, AD, 8'h00, 8'h00, "empty_data"};
    vt[2] = '{1'b0, AC, 8'h00, 8'h00, "rst_ctrl"};
    vt[3] = '{1'b1, AC, 8'hff, 8'h00, "ctrl_wr"};
    vt[4] = '{1'b0, AC, 8'h00, CTRL_RB, "ctrl_rb"};
    vt[5] = '{1'b1, AC, 8'h00, 8'h00, "ctrl_wr0"};
    vt[6] = '{1'b0, AC, 8'h00, 8'h00, "ctrl_zero"};
    vt[7] = '{1'b1, AK, 8'hff, 8'h00, "clr_wr"};
    vt[8] = '{1'b0, AK, 8'h00, 8'h00, "clr_rd"};
    vt[9] = '{1'b0, AS, 8'h00, 8'h00, "status_idle"};
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_ld", 8'(u_txd_ld), 8'h00);
    chk("rst_ft", 8'(u_rxd_ft), 8'h00);
    chk("rst_din", u_din, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 10; i++)
      if (vt[i].wr) bus_wr(vt[i].a, vt[i].wd);
      else bus_rd(vt[i].a, vt[i].exp, vt[i].n);
    base = ld_cnt;
    tx_sb.push_back(8'h41);
    @(negedge clk);
    addr = AD; wdata = 8'h41; wr_en = 1'b1; wcyc = cyc;
    @(negedge clk);
    wr_en = 1'b0;
    idle(4);
    chk("tx_ld_once", 8'(ld_cnt - base), 8'd1);
    chk("tx_latency", 8'((ld_cyc - wcyc) inside {[1:2]}), 8'd1);
    bus_rd(AS, 8'h00, "tx_pend_clr");
    base = ld_cnt;
    u_txd_busy = 1'b1;
    bus_wr(AD, 8'h55);
    bus_wr(AD, 8'h66);
    idle(20);
    chk("busy_no_ld", 8'(ld_cnt - base), 8'd0);
    bus_rd(AS, 8'h0a, "busy_status");
    tx_sb.push_back(8'h55);
    u_txd_busy = 1'b0;
    idle(5);
    chk("drop_one_ld", 8'(ld_cnt - base), 8'd1);
    bus_rd(AS, 8'h08, "drop_status");
    bus_wr(AK, 8'h02);
    bus_rd(AS, 8'h00, "drop_clr");
    for (int b = 8'h10; b <= 8'h14; b++) rx_byte(8'(b));
    bus_rd(AS, 8'h05, "ovf_status");
    idle(2);
    chk("rdata_hold", rdata, 8'h05);
    for (int b = 8'h10; b <= 8'h13; b++) bus_rd(AD, 8'(b), "ovf_data");
    bus_rd(AD, 8'h00, "ovf_empty");
    bus_rd(AS, 8'h04, "ovf_only");
    bus_wr(AK, 8'h01);
    bus_rd(AS, 8'h00, "ovf_clr");
    for (int b = 8'h20; b <= 8'h23; b++) rx_byte(8'(b));
    @(negedge clk);
    u_dout = 8'h24; u_rxd_rdy = 1'b1;
    @(negedge clk);
    addr = AD; rd_en = 1'b1;
    rd_sb.push_back(8'h20);
    nm_sb.push_back("full_rw_head");
    @(negedge clk);
    rd_en = 1'b0;
    chk("full_rw_ft", 8'(u_rxd_ft), 8'd1);
    u_rxd_rdy = 1'b0;
    bus_rd(AS, 8'h01, "full_rw_status");
    for (int b = 8'h21; b <= 8'h24; b++) bus_rd(AD, 8'(b), "full_rw_data");
    bus_rd(AD, 8'h00, "full_rw_empty");
`ifdef UART_CTRL_IRQ_EN
    bus_wr(AC, 8'h01);
    rx_byte(8'h5a);
    idle(2);
    chk("irq_set", 8'(irq), 8'd1);
    @(negedge clk);
    addr = AD; rd_en = 1'b1;
    rd_sb.push_back(8'h5a);
    nm_sb.push_back("irq_data");
    @(negedge clk);
    rd_en = 1'b0;
    chk("irq_hold", 8'(irq), 8'd1);
    @(negedge clk);
    chk("irq_drop", 8'(irq), 8'd0);
    bus_wr(AC, 8'h00);
`else
    bus_wr(AC, 8'h01);
    rx_byte(8'h5a);
    idle(2);
    chk("irq_tied", 8'(irq), 8'd0);
    bus_rd(AD, 8'h5a, "irq_data");
    bus_rd(AC, 8'h00, "ctrl_ignored");
`endif
    base = ld_cnt;
    @(negedge clk);
    addr = AD; wdata = 8'h77; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; addr = AS; rd_en = 1'b1;
    rd_sb.push_back(8'h02);
    nm_sb.push_back("pre_rst_status");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ld", 8'(u_txd_ld), 8'h00);
    chk("abort_rdata", rdata, 8'h00);
    chk("abort_din", u_din, 8'h00);
    chk("abort_ft", 8'(u_rxd_ft), 8'h00);
    chk("abort_irq", 8'(irq), 8'h00);
    @(negedge clk);
    rd_en = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(4);
    chk("abort_no_ld", 8'(ld_cnt - base), 8'd0);
    bus_rd(AS, 8'h00, "post_rst_status");
    idle(2);
    chk("rd_sb_drained", 8'(rd_sb.size()), 8'd0);
    chk("tx_sb_drained", 8'(tx_sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
